led_blink_arbiter: RTL
======================

// Module: led_blink_arbiter
// PURPOSE
//  Shares one board LED between N_REQ requesters. Each requester asks for a
//  burst of K blinks; a round-robin arbiter grants one requester at a time.
//  The granted burst is timed by an internal half-period counter, and a fixed
//  dark gap separates consecutive bursts. Used as the LED status/debug channel
//  for multi-unit labs on the 25 MHz Go Board.
// PARAMETERS
//  N_REQ        4           number of requesters (2..8)
//  CNT_W        4           width of the per-requester blink-count field
//  HALF_CYCLES  12_500_000  clock cycles per LED on-phase and per off-phase (>=1)
//  GAP_CYCLES   12_500_000  dark cycles after each burst (0 = no gap)
// PORTS
//  i_clk     in   1            25 MHz system clock
//  i_rst     in   1            reset, synchronous, active-high
//  i_req     in   N_REQ        level request; hold high until o_done pulse
//  i_blinks  in   N_REQ*CNT_W  blink count for req n at [n*CNT_W +: CNT_W]
//  o_grant   out  N_REQ        one-hot grant; all zero when idle or in gap
//  o_done    out  N_REQ        one-cycle pulse when req n's burst completes
//  o_busy    out  1            high in any state except IDLE
//  o_led     out  1            active-low LED drive (1 = dark)
// BEHAVIOUR
//  Interface: one clock, i_clk. Reset is synchronous and active-high on i_rst.
//  Reset values: state=IDLE, o_grant=0, o_done=0, o_busy=0, o_led=1, rr pointer=0,
//   timer=0, remaining=0.
//  States: IDLE, ON, OFF, GAP.
//  IDLE: at an edge with i_req!=0, pick the first set bit searching upward
//   (mod N_REQ) from the rr pointer.
//   - Latch its i_blinks into remaining.
//   - Set o_grant one-hot at the next cycle and set the pointer to winner+1.
//   - remaining!=0: go to ON with o_led=0. The LED lights in the same cycle that
//     the grant appears.
//   - remaining==0: grant for exactly 1 cycle. o_done pulses in that cycle, the
//     LED stays dark, then go to GAP.
//  ON: o_led=0 for HALF_CYCLES cycles, then go to OFF.
//  OFF: o_led=1 for HALF_CYCLES cycles. At the end, decrement remaining.
//   - Result 0: o_done[winner] pulses on the last OFF cycle, o_grant clears on
//     the next cycle, and go to GAP.
//   - Result nonzero: go to ON.
//  GAP: o_led=1 and o_grant=0 for GAP_CYCLES cycles, then go to IDLE.
//   If GAP_CYCLES==0, skip GAP and go straight to IDLE.
//  i_blinks is sampled only at grant. Changes during a burst are ignored.
//  Abort: if i_req[winner] falls while in ON or OFF:
//   - next cycle: o_led=1, o_grant=0, no o_done, and go to GAP;
//   - the rr pointer is still advanced.
//  A request that rises during ON/OFF/GAP waits and is arbitrated only in IDLE.
//   No request is ever granted twice in a row while another is pending.
//  Timer: one shared down-counter of width $clog2(max(HALF_CYCLES,GAP_CYCLES)+1),
//   reloaded on each state entry. There is no free-running wrap.
//  remaining is CNT_W bits and never underflows (the decrement is gated at 0).
//  o_busy = (state!=IDLE).
//  o_done is registered and is never high for more than 1 cycle.
//  Reset mid-burst: the cycle after i_rst is sampled high, all outputs hold
//   their reset values. No o_done is emitted for the interrupted burst.
// STRUCTURE
//  Shared package led_pkg.vh: CLK_HZ=25_000_000 and the default HALF_CYCLES /
//   GAP_CYCLES constants, reused by all LED blocks.
//  State encodings are local to this module.
//  Sub-module rr_pick (combinational): inputs req vector and pointer; outputs a
//   one-hot winner and its index. Instantiated once; unit-tested separately.
// TESTING (sim params: N_REQ=4, CNT_W=4, HALF_CYCLES=4, GAP_CYCLES=3)
//  1. req0, blinks=2 -> grant0 one cycle after req. LED 0x4,1x4,0x4,1x4 cycles.
//     done0 pulses on cycle 16 of the grant, then 3 dark gap cycles, then IDLE.
//  2. All reqs high from reset, blinks=1 each -> grant order 0,1,2,3,0.
//     Each burst is 8 cycles, separated by 3-cycle gaps.
//  3. req2, blinks=0 -> grant2 for 1 cycle with done2 in the same cycle.
//     LED never goes low. Next grant comes after the gap.
//  4. req1, blinks=3; drop req1 in the 2nd ON phase -> LED=1 and grant=0 next
//     cycle, no done1. Pending req3 is granted after the 3-cycle gap.
//  5. i_rst pulse during OFF of a burst -> next cycle all outputs at reset
//     values, no done. A later req0/req1 tie grants req0 (pointer reset).
//  6. req3 rises in the same cycle as done0 -> grant3 only after the gap.
//     i_blinks3 changing mid-burst leaves the burst length unchanged.

Source files
------------

// File: rtl/led_blink_arbiter_pkg.sv
// Shared constants for the LED blocks on the 25 MHz Go Board, plus small
// elaboration-time helpers used to size counters and indices.
package led_blink_arbiter_pkg;

  localparam int unsigned CLK_HZ              = 25_000_000;
  localparam int unsigned DEFAULT_HALF_CYCLES = 12_500_000;
  localparam int unsigned DEFAULT_GAP_CYCLES  = 12_500_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_blink_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// (modulo N_REQ) from ptr, returned both one-hot and as an index.
module rr_pick
  import led_blink_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IW'((32'(ptr) + k) % N_REQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_blink_arbiter.sv
// Shares one active-low board LED between N_REQ requesters: round-robin grant,
// K on/off blinks per burst, then a fixed dark gap before the next arbitration.
module led_blink_arbiter
  import led_blink_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned HALF_CYCLES = DEFAULT_HALF_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*CNT_W-1:0] i_blinks,
  output logic [N_REQ-1:0]       o_grant,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_busy,
  output logic                   o_led
);

  localparam int unsigned IW = idx_width(N_REQ);
  localparam int unsigned TW = $clog2(max_u(HALF_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF_CYCLES - 1);
  localparam logic [TW-1:0] GAP_RELOAD  = TW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] remaining;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic [IW-1:0]    ptr_next;
  logic [CNT_W-1:0] blinks_sel;
  logic             in_burst;
  logic             abort;
  logic             burst_end;
  logic             last_off_next;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (i_req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    blinks_sel = '0;
    for (int unsigned n = 0; n < N_REQ; n++) begin
      if (pick_onehot[n]) blinks_sel = blinks_sel | i_blinks[n*CNT_W +: CNT_W];
    end
    ptr_next  = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
    in_burst  = (state == S_ON) || (state == S_OFF);
    abort     = in_burst && ((i_req & o_grant) == '0);
    // remaining<=1 at the end of OFF means the decrement lands on (or stays at) 0
    burst_end = (state == S_OFF) && (timer == '0) && (remaining <= CNT_W'(1));
    // o_done is registered, so it is launched on the edge entering the last OFF cycle
    last_off_next = (remaining == CNT_W'(1)) &&
                    (((state == S_ON)  && (timer == '0) && (HALF_CYCLES == 1)) ||
                     ((state == S_OFF) && (timer == TW'(1))));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      timer     <= '0;
      remaining <= '0;
      o_grant   <= '0;
      o_done    <= '0;
      o_busy    <= 1'b0;
      o_led     <= 1'b1;
    end else begin
      o_done <= '0;
      if (abort || burst_end) begin
        o_grant   <= '0;
        o_led     <= 1'b1;
        remaining <= '0;
        if (GAP_CYCLES == 0) begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
          timer  <= '0;
        end else begin
          state <= S_GAP;
          timer <= GAP_RELOAD;
        end
      end else begin
        unique case (state)
          S_IDLE: begin
            if (pick_valid) begin
              o_grant   <= pick_onehot;
              ptr       <= ptr_next;
              remaining <= blinks_sel;
              o_busy    <= 1'b1;
              if (blinks_sel != '0) begin
                state <= S_ON;
                o_led <= 1'b0;
                timer <= HALF_RELOAD;
              end else begin
                // Zero-blink grant: a single dark OFF cycle with done, then the gap
                state  <= S_OFF;
                o_led  <= 1'b1;
                timer  <= '0;
                o_done <= pick_onehot;
              end
            end
          end
          S_ON: begin
            if (timer == '0) begin
              state <= S_OFF;
              o_led <= 1'b1;
              timer <= HALF_RELOAD;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          S_OFF: begin
            if (timer == '0) begin
              state     <= S_ON;
              o_led     <= 1'b0;
              timer     <= HALF_RELOAD;
              remaining <= remaining - CNT_W'(1);
            end else begin
              timer <= timer - TW'(1);
            end
          end
          S_GAP: begin
            if (timer == '0) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
        if (last_off_next) o_done <= o_grant;
      end
    end
  end

endmodule
